// File: rtl/prbs6_checker.sv
// PRBS6 (x^6 + x^5 + 1) sequence checker: hunts for alignment on a qualified word stream,
// locks after a run of correct predictions, then counts mismatches and drops lock on sustained errors.
module prbs6_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           data_in,
    input  logic                 data_valid,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lost_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    localparam logic [3:0]           LockCnt = 4'(LOCK_COUNT);
    localparam logic [3:0]           LossCnt = 4'(LOSS_COUNT);
    localparam logic [ERR_CNT_W-1:0] CntOne  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [5:0] predict(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4]};
    endfunction

    state_e               state_q, state_d;
    logic [5:0]           prev_q, prev_d;
    logic [5:0]           expected_q, expected_d;
    logic                 prev_ok_q, prev_ok_d;
    logic [3:0]           good_run_q, good_run_d;
    logic [3:0]           bad_run_q, bad_run_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 lost_pulse_q, lost_pulse_d;
    logic                 hunt_match;
    logic                 word_err;
    logic [3:0]           good_inc;
    logic [3:0]           bad_inc;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        expected_d   = expected_q;
        prev_ok_d    = prev_ok_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        err_count_d  = err_count_q;
        err_pulse_d  = 1'b0;
        lost_pulse_d = 1'b0;

        // The all-zero word is the LFSR lockup state and must never count as a match.
        hunt_match = prev_ok_q && (data_in == predict(prev_q)) && (data_in != 6'd0);
        word_err   = (data_in != expected_q);
        good_inc   = good_run_q + 4'd1;
        bad_inc    = bad_run_q + 4'd1;

        if (data_valid) begin
            unique case (state_q)
                StHunt: begin
                    prev_d    = data_in;
                    prev_ok_d = (data_in != 6'd0);
                    if (prev_ok_q) begin
                        good_run_d = hunt_match ? good_inc : 4'd0;
                        if (hunt_match && (good_inc == LockCnt)) begin
                            state_d    = StLocked;
                            expected_d = predict(data_in);
                            bad_run_d  = 4'd0;
                        end
                    end
                end
                StLocked: begin
                    // Free-running prediction: a single corrupted word costs exactly one error.
                    expected_d = predict(expected_q);
                    if (word_err) begin
                        err_pulse_d = 1'b1;
                        bad_run_d   = bad_inc;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CntOne;
                        end
                        if (bad_inc == LossCnt) begin
                            state_d      = StHunt;
                            lost_pulse_d = 1'b1;
                            good_run_d   = 4'd0;
                            prev_d       = data_in;
                            prev_ok_d    = (data_in != 6'd0);
                        end
                    end else begin
                        bad_run_d = 4'd0;
                    end
                end
                default: ;
            endcase
        end

        if (clear_cnt) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            prev_q       <= 6'd0;
            expected_q   <= 6'd0;
            prev_ok_q    <= 1'b0;
            good_run_q   <= 4'd0;
            bad_run_q    <= 4'd0;
            err_count_q  <= '0;
            err_pulse_q  <= 1'b0;
            lost_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            expected_q   <= expected_d;
            prev_ok_q    <= prev_ok_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            err_count_q  <= err_count_d;
            err_pulse_q  <= err_pulse_d;
            lost_pulse_q <= lost_pulse_d;
        end
    end

    assign locked     = (state_q == StLocked);
    assign err_pulse  = err_pulse_q;
    assign lost_pulse = lost_pulse_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_prbs6_checker.sv
// Randomized bench for prbs6_checker; the reference tracks position in the 63-word sequence
// table rather than the predicted word itself.
module tb_prbs6_checker;

    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned LOSS_COUNT = 3;
    localparam int unsigned ERR_CNT_W  = 4;
    localparam int          ERR_MAX    = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [5:0]           data_in = 6'd0;
    logic                 data_valid = 1'b0;
    logic                 clear_cnt = 1'b0;
    logic                 locked;
    logic                 err_pulse;
    logic                 lost_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    prbs6_checker #(
        .LOCK_COUNT(LOCK_COUNT),
        .LOSS_COUNT(LOSS_COUNT),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lost_pulse(lost_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [5:0] seq [63];

    bit         m_locked, m_prev_ok, m_ep, m_lp;
    int         m_pos, m_good, m_bad, m_err;
    logic [5:0] m_prev;

    function automatic int idx_of(input logic [5:0] v);
        for (int i = 0; i < 63; i++) if (seq[i] == v) return i;
        return -1;
    endfunction

    function automatic logic [ERR_CNT_W+2:0] exp_vec();
        return {m_locked, m_ep, m_lp, m_err[ERR_CNT_W-1:0]};
    endfunction

    function automatic logic [5:0] next_good();
        if (m_locked) return seq[m_pos];
        if (m_prev_ok) return seq[(idx_of(m_prev) + 1) % 63];
        return seq[$urandom_range(0, 62)];
    endfunction

    task automatic model_step(input bit rst, input bit v, input logic [5:0] d, input bit clr);
        m_ep = 0;
        m_lp = 0;
        if (!rst) begin
            m_locked = 0; m_prev_ok = 0; m_pos = 0; m_good = 0; m_bad = 0; m_err = 0;
            m_prev = 6'd0;
            return;
        end
        if (v) begin
            if (!m_locked) begin
                if (m_prev_ok) begin
                    if (d != 0 && d == seq[(idx_of(m_prev) + 1) % 63]) m_good++;
                    else m_good = 0;
                    if (m_good == LOCK_COUNT) begin
                        m_locked = 1;
                        m_pos    = (idx_of(d) + 1) % 63;
                        m_bad    = 0;
                    end
                end
                m_prev    = d;
                m_prev_ok = (d != 0);
            end else begin
                if (d != seq[m_pos]) begin
                    m_ep = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_bad++;
                    if (m_bad == LOSS_COUNT) begin
                        m_locked  = 0;
                        m_lp      = 1;
                        m_good    = 0;
                        m_prev    = d;
                        m_prev_ok = (d != 0);
                    end
                end else begin
                    m_bad = 0;
                end
                m_pos = (m_pos + 1) % 63;
            end
        end
        if (clr) m_err = 0;
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
    task automatic step(input bit v, input logic [5:0] d, input bit clr);
        data_valid = v;
        data_in    = d;
        clear_cnt  = clr;
        @(posedge clk);
        model_step(rst_n, v, d, clr);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 6'($urandom), 1'b0);
            n_vec++;
            if ({locked, err_pulse, lost_pulse, err_count} !== '0) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %b want 0", i,
                         {locked, err_pulse, lost_pulse, err_count});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_acquire();
        for (int i = 0; i < 76; i++) begin
            step(1'b1, seq[i % 63], 1'b0);
            n_vec++;
            if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_acquire word %0d: got %b want %b", i,
                         {locked, err_pulse, lost_pulse, err_count}, exp_vec());
            end
            if (i == 3 || i == 4) begin
                n_vec++;
                if (locked !== (i == 4)) begin
                    n_bad++;
                    $display("FAIL lock_edge word %0d: locked=%b want %b", i, locked, i == 4);
                end
            end
        end
    endtask

    task automatic test_single_error_gaps();
        logic [5:0] w;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                w = (j == 0) ? (seq[m_pos] ^ 6'($urandom_range(1, 63))) : seq[m_pos];
                step(1'b1, w, 1'b0);
                n_vec++;
                if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL single_err k%0d j%0d: got %b want %b", k, j,
                             {locked, err_pulse, lost_pulse, err_count}, exp_vec());
                end
                repeat ($urandom_range(1, 3)) begin
                    step(1'b0, 6'($urandom), 1'b0);
                    n_vec++;
                    if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                        n_bad++;
                        $display("FAIL gap k%0d: got %b want %b", k,
                                 {locked, err_pulse, lost_pulse, err_count}, exp_vec());
                    end
                end
            end
        end
    endtask

    task automatic drive_to_lock(input string name);
        for (int i = 0; i < 40 && !m_locked; i++) begin
            step(1'b1, next_good(), 1'b0);
            n_vec++;
            if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                n_bad++;
                $display("FAIL %s relock %0d: got %b want %b", name, i,
                         {locked, err_pulse, lost_pulse, err_count}, exp_vec());
            end
        end
        n_vec++;
        if (locked !== 1'b1 || !m_locked) begin
            n_bad++;
            $display("FAIL %s lock_timeout: locked=%b want 1", name, locked);
        end
    endtask

    task automatic test_loss_relock();
        drive_to_lock("loss_pre");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[m_pos] ^ 6'($urandom_range(1, 63)), 1'b0);
            n_vec++;
            if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                n_bad++;
                $display("FAIL loss bad %0d: got %b want %b", i,
                         {locked, err_pulse, lost_pulse, err_count}, exp_vec());
            end
        end
        n_vec++;
        if (lost_pulse !== 1'b1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL loss_edge: lost=%b locked=%b want 1 0", lost_pulse, locked);
        end
        step(1'b1, seq[$urandom_range(0, 62)], 1'b0);
        n_vec++;
        if (lost_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL lost_width: lost=%b want 0", lost_pulse);
        end
        drive_to_lock("relock");
    endtask

    task automatic test_zero_lockup();
        drive_to_lock("zero_pre");
        step(1'b1, 6'd0, 1'b0);
        n_vec++;
        if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec() || err_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_locked: got %b want %b", {locked, err_pulse, lost_pulse, err_count},
                     exp_vec());
        end
        for (int i = 0; i < 3; i++) step(1'b1, seq[m_pos] ^ 6'h3F, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 6'd0, 1'b0);
            n_vec++;
            if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec() || locked !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_hunt %0d: got %b want %b", i,
                         {locked, err_pulse, lost_pulse, err_count}, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        drive_to_lock("sat_pre");
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 2; j++) begin
                step(1'b1, (j == 0) ? (seq[m_pos] ^ 6'($urandom_range(1, 63))) : seq[m_pos],
                     1'b0);
                n_vec++;
                if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL saturate %0d/%0d: got %b want %b", i, j,
                             {locked, err_pulse, lost_pulse, err_count}, exp_vec());
                end
            end
        end
        n_vec++;
        if (err_count !== 4'hF || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_hold: count=%0d locked=%b want 15 1", err_count, locked);
        end
        step(1'b1, seq[m_pos] ^ 6'h01, 1'b1);
        n_vec++;
        if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec() || err_count !== 4'd0
            || err_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_priority: got %b want %b", {locked, err_pulse, lost_pulse,
                     err_count}, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [5:0] w;
        bit         v, c;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            w = ($urandom_range(0, 9) < 8) ? next_good() : 6'($urandom);
            step(v, w, c);
            n_vec++;
            if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %b want %b", i,
                         {locked, err_pulse, lost_pulse, err_count}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midlock();
        drive_to_lock("rst_pre");
        step(1'b1, seq[m_pos] ^ 6'h04, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 6'($urandom), 1'b0);
        n_vec++;
        if ({locked, err_pulse, lost_pulse, err_count} !== '0 || exp_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset_midlock: got %b want 0", {locked, err_pulse, lost_pulse,
                     err_count});
        end
        rst_n = 1'b1;
        step(1'b1, seq[10], 1'b0);
        step(1'b1, seq[11], 1'b0);
        n_vec++;
        if ({locked, err_pulse, lost_pulse, err_count} !== exp_vec()) begin
            n_bad++;
            $display("FAIL post_reset: got %b want %b", {locked, err_pulse, lost_pulse,
                     err_count}, exp_vec());
        end
    endtask

    initial begin
        seq[0] = 6'h01;
        for (int i = 1; i < 63; i++) seq[i] = {seq[i-1][4:0], seq[i-1][5] ^ seq[i-1][4]};
        model_step(1'b0, 1'b0, 6'd0, 1'b0);

        test_reset();
        test_lock_acquire();
        test_single_error_gaps();
        test_loss_relock();
        test_zero_lockup();
        test_saturation();
        test_random();
        test_reset_midlock();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
